// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC sequencer.
package mac_seq_pkg;

    localparam int DATA_W      = 8;
    localparam int ACC_W       = 32;
    localparam int VEC_LEN_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUT    = 2'd3
    } state_t;

endpackage

// File: rtl/vec_buffer.sv
// VEC_LEN x DATA_W register file: one synchronous write port, one combinational read port.
module vec_buffer
    import mac_seq_pkg::*;
#(
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int ADDR_W  = $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [VEC_LEN];

    // No reset: contents are undefined until software loads them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_seq.sv
// Streams buffered activation/weight pairs into the MAC and reports acc delta as the dot product.
// Build option: MAC_SEQ_RELU_EN clamps negative results to zero.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | buffers writable, waiting for start
// S_STREAM | driving len pairs into the MAC
// S_DRAIN  | inputs done, waiting for remaining valid_out
// S_OUT    | result presented, waiting for res_ready
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int ADDR_W  = $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              err,
    output logic [DATA_W-1:0] mac_in_data,
    output logic [DATA_W-1:0] mac_weight,
    output logic              mac_valid_in,
    input  logic [ACC_W-1:0]  mac_acc_out,
    input  logic              mac_valid_out,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_valid,
    input  logic              res_ready
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(VEC_LEN);

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   cnt;
    logic [ACC_W-1:0]  baseline;
    logic [ACC_W-1:0]  diff;
    logic [ACC_W-1:0]  res_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] act_rd;
    logic [DATA_W-1:0] wgt_rd;
    logic              wr_ok;

    assign wr_ok   = wr_en && (state == S_IDLE);
    // In IDLE the read port presents element 0 so the first pair leaves on the start edge.
    assign rd_addr = (state == S_IDLE) ? '0 : idx[ADDR_W-1:0];

    vec_buffer #(.VEC_LEN(VEC_LEN), .ADDR_W(ADDR_W)) u_act (
        .clk     (clk),
        .wr_en   (wr_ok && !wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (act_rd)
    );

    vec_buffer #(.VEC_LEN(VEC_LEN), .ADDR_W(ADDR_W)) u_wgt (
        .clk     (clk),
        .wr_en   (wr_ok && wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (wgt_rd)
    );

    // The MAC cannot be cleared, so the result is the accumulator delta; wrap cancels out.
    assign diff = mac_acc_out - baseline;

`ifdef MAC_SEQ_RELU_EN
    assign res_next = diff[ACC_W-1] ? '0 : diff;
`else
    assign res_next = diff;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len_q        <= '0;
            idx          <= '0;
            cnt          <= '0;
            baseline     <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
            mac_valid_in <= 1'b0;
            mac_in_data  <= '0;
            mac_weight   <= '0;
            res_data     <= '0;
            res_valid    <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len == '0 || len > LEN_MAX) begin
                            err <= 1'b1;
                        end else begin
                            len_q        <= len;
                            baseline     <= mac_acc_out;
                            idx          <= (ADDR_W+1)'(1);
                            cnt          <= '0;
                            busy         <= 1'b1;
                            mac_valid_in <= 1'b1;
                            mac_in_data  <= act_rd;
                            mac_weight   <= wgt_rd;
                            state        <= S_STREAM;
                        end
                    end
                end
                S_STREAM, S_DRAIN: begin
                    if (state == S_STREAM) begin
                        if (idx == len_q) begin
                            mac_valid_in <= 1'b0;
                            mac_in_data  <= '0;
                            mac_weight   <= '0;
                            state        <= S_DRAIN;
                        end else begin
                            mac_in_data <= act_rd;
                            mac_weight  <= wgt_rd;
                            idx         <= idx + 1'b1;
                        end
                    end
                    if (mac_valid_out) begin
                        if (cnt == len_q - 1'b1) begin
                            res_data     <= res_next;
                            res_valid    <= 1'b1;
                            mac_valid_in <= 1'b0;
                            mac_in_data  <= '0;
                            mac_weight   <= '0;
                            state        <= S_OUT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq driving a behavioural 8-bit MAC (one-cycle latency, no clear).
module tb_mac_seq;

    localparam int VL = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          busy, err;
    logic [7:0]    mac_in_data, mac_weight;
    logic          mac_valid_in;
    logic [31:0]   mac_acc_out;
    logic          mac_valid_out;
    logic [31:0]   res_data;
    logic          res_valid;
    logic          res_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    mac_seq #(.VEC_LEN(VL), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .len           (len),
        .busy          (busy),
        .err           (err),
        .mac_in_data   (mac_in_data),
        .mac_weight    (mac_weight),
        .mac_valid_in  (mac_valid_in),
        .mac_acc_out   (mac_acc_out),
        .mac_valid_out (mac_valid_out),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready)
    );

    always #5 clk = ~clk;

    // MAC model: registered accumulate, valid_out one cycle after valid_in.
    logic signed [15:0] prod;
    assign prod = $signed(mac_in_data) * $signed(mac_weight);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_acc_out   <= '0;
            mac_valid_out <= 1'b0;
        end else begin
            mac_valid_out <= mac_valid_in;
            if (mac_valid_in) mac_acc_out <= mac_acc_out + {{16{prod[15]}}, prod};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int addr, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr[AW-1:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic run_dot(input string tag, input int n, input logic [31:0] exp);
        int t;
        int nv;
        start = 1'b1;
        len   = n[AW:0];
        tick();
        start = 1'b0;
        t  = 1;
        nv = 0;
        while (!res_valid && t < 100) begin
            if (mac_valid_in) nv++;
            tick();
            t++;
        end
        check({tag, "_vin_cycles"}, nv, n);
        check({tag, "_latency"}, t, n + 2);
        check({tag, "_res"}, res_data, exp);
        tick();
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_vin"}, {31'd0, mac_valid_in}, 32'd0);
        check({tag, "_in_data"}, {24'd0, mac_in_data}, 32'd0);
        check({tag, "_weight"}, {24'd0, mac_weight}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_res_data"}, res_data, 32'd0);
    endtask

    logic [31:0] neg_exp;

    initial begin
        int t;
`ifdef MAC_SEQ_RELU_EN
        neg_exp = 32'h0000_0000;
`else
        neg_exp = 32'hFFFF_FFEE;
`endif
        tick();
        reset_outputs("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // Basic and back-to-back (nonzero baseline).
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, i, 8'd1);
            wr(1'b1, i, 8'(i + 1));
        end
        run_dot("basic", 4, 32'd10);
        run_dot("b2b", 4, 32'd10);
        check("b2b_mac_acc", mac_acc_out, 32'd20);

        // Negative result: 3 * (-2 * 3) = -18.
        for (int i = 0; i < 3; i++) begin
            wr(1'b0, i, 8'hFE);
            wr(1'b1, i, 8'd3);
        end
        run_dot("neg", 3, neg_exp);

        // Backpressure: result held; start and writes ignored.
        for (int i = 0; i < 3; i++) begin
            wr(1'b0, i, 8'd1);
            wr(1'b1, i, 8'(i + 1));
        end
        res_ready = 1'b0;
        start = 1'b1;
        len = 5'd4;
        tick();
        start = 1'b0;
        t = 0;
        while (!res_valid && t < 100) begin
            tick();
            t++;
        end
        check("bp_valid", {31'd0, res_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            start   = 1'b1;
            len     = 5'd2;
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = '0;
            wr_data = 8'h63;
            tick();
            check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
            check("bp_hold_data", res_data, 32'd10);
            check("bp_err", {31'd0, err}, 32'd0);
            check("bp_vin", {31'd0, mac_valid_in}, 32'd0);
        end
        start = 1'b0;
        wr_en = 1'b0;
        res_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, res_valid}, 32'd0);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        run_dot("bp_after", 4, 32'd10);

        // Rejected starts.
        start = 1'b1;
        len = 5'd0;
        tick();
        start = 1'b0;
        check("rej0_err", {31'd0, err}, 32'd1);
        check("rej0_busy", {31'd0, busy}, 32'd0);
        check("rej0_vin", {31'd0, mac_valid_in}, 32'd0);
        tick();
        check("rej0_err_pulse", {31'd0, err}, 32'd0);
        start = 1'b1;
        len = 5'd17;
        tick();
        start = 1'b0;
        check("rej17_err", {31'd0, err}, 32'd1);
        check("rej17_busy", {31'd0, busy}, 32'd0);
        check("rej17_vin", {31'd0, mac_valid_in}, 32'd0);
        tick();
        check("rej17_err_pulse", {31'd0, err}, 32'd0);
        check("rej17_busy2", {31'd0, busy}, 32'd0);

        // Reset in the middle of a len = 8 run.
        for (int i = 0; i < 8; i++) begin
            wr(1'b0, i, 8'd3);
            wr(1'b1, i, 8'd1);
        end
        start = 1'b1;
        len = 5'd8;
        tick();
        start = 1'b0;
        tick();
        check("mid_vin_before", {31'd0, mac_valid_in}, 32'd1);
        rst_n = 1'b0;
        #1;
        reset_outputs("mid_rst");
        tick();
        reset_outputs("mid_rst_next");
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            wr(1'b0, i, 8'd5);
            wr(1'b1, i, 8'd2);
        end
        run_dot("after_rst", 2, 32'd20);

        // Boundaries: full length and single element.
        for (int i = 0; i < VL; i++) begin
            wr(1'b0, i, 8'd2);
            wr(1'b1, i, 8'(i));
        end
        run_dot("full_len", VL, 32'd240);
        wr(1'b1, 0, 8'd7);
        run_dot("len1", 1, 32'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
